// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, reads the word memory and queues {pc, instr} pairs for decode.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_queue #(
   parameter int          DEPTH       = 2,
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] PC_STEP     = 16'd1,
   parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [15:0]                imem_addr,
   output logic                       imem_enable,
   output logic                       imem_wr,
   input  logic [15:0]                imem_data,
   input  logic                       redirect_valid,
   input  logic [15:0]                redirect_pc,
   output logic                       dec_valid,
   input  logic                       dec_ready,
   output logic [15:0]                dec_instr,
   output logic [15:0]                dec_pc,
   output logic [15:0]                dec_pc_next,
   output logic                       halted,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [15:0]                perf_fetch_cnt,
   output logic [15:0]                perf_stall_cnt
);

   localparam int                PTR_W = $clog2(DEPTH);
   localparam int                OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0]  FULL  = OCC_W'(DEPTH);

   logic [15:0]      pc_q, pc_d;
   logic             halted_q, halted_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   // Queue payload is not reset: it is only observable through the occupancy-gated outputs.
   logic [15:0]      fifo_pc_q    [DEPTH];
   logic [15:0]      fifo_instr_q [DEPTH];

   logic             full;
   logic             head_valid;
   logic             pop;
   logic             fetch;

   always_comb begin
      full       = (occ_q == FULL);
      head_valid = (occ_q != '0);
      pop        = head_valid & dec_ready;
      fetch      = ~redirect_valid & ~halted_q & (~full | pop);

      pc_d     = pc_q;
      halted_d = halted_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      if (redirect_valid) begin
         // A redirect drops every queued entry, including one decode takes this cycle.
         pc_d     = redirect_pc;
         halted_d = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (fetch) begin
            pc_d     = pc_q + PC_STEP;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (imem_data[15:11] == HALT_OPCODE) begin
               halted_d = 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({fetch, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fetch) begin
         fifo_pc_q[wr_ptr_q]    <= pc_q;
         fifo_instr_q[wr_ptr_q] <= imem_data;
      end
   end

   assign imem_addr   = pc_q;
   assign imem_enable = fetch;
   assign imem_wr     = 1'b0;
   assign halted      = halted_q;
   assign occupancy   = occ_q;
   assign dec_valid   = head_valid;
   assign dec_instr   = head_valid ? fifo_instr_q[rd_ptr_q] : 16'h0000;
   assign dec_pc      = head_valid ? fifo_pc_q[rd_ptr_q] : 16'h0000;
   assign dec_pc_next = head_valid ? (fifo_pc_q[rd_ptr_q] + PC_STEP) : 16'h0000;

`ifdef FETCH_PERF_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (fetch) begin
         fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
      if (full & ~pop & ~halted_q & ~redirect_valid) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= 16'h0000;
         stall_cnt_q <= 16'h0000;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`else
   assign perf_fetch_cnt = 16'h0000;
   assign perf_stall_cnt = 16'h0000;
`endif

endmodule
